// File: rtl/zxb_mem_arbiter.sv
// Arbiter sharing the single-port 8-bit board SRAM between ZX-bus, DMA and host clients.
// ZX-bus may take strict priority; the remaining clients are served round-robin.
module zxb_mem_arbiter #(
  parameter int AW         = 19,
  parameter int ACC_CYCLES = 2,
  parameter bit ZXB_PRIO   = 1'b1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          zxb_req,
  input  logic          zxb_rnw,
  input  logic [AW-1:0] zxb_addr,
  input  logic [7:0]    zxb_wdata,
  output logic          zxb_stb,
  input  logic          dma_req,
  input  logic          dma_rnw,
  input  logic [AW-1:0] dma_addr,
  input  logic [7:0]    dma_wdata,
  output logic          dma_stb,
  input  logic          hst_req,
  input  logic          hst_rnw,
  input  logic [AW-1:0] hst_addr,
  input  logic [7:0]    hst_wdata,
  output logic          hst_stb,
  output logic [7:0]    rdata,
  output logic [AW-1:0] sram_addr,
  output logic [7:0]    sram_dout,
  output logic          sram_doe,
  input  logic [7:0]    sram_din,
  output logic          sram_we_n,
  output logic          sram_oe_n,
  output logic [1:0]    grant,
  output logic          busy
);

  typedef enum logic [1:0] {IDLE, ACCESS, RECOV} state_t;
  typedef enum logic [1:0] {C_NONE = 2'd0, C_ZXB = 2'd1, C_DMA = 2'd2, C_HST = 2'd3} client_t;

  state_t          state, state_d;
  client_t         owner, owner_d;
  client_t         rr_ptr, rr_d;
  client_t         win, rr_adv;
  logic [3:0]      cnt, cnt_d;
  logic            rnw, rnw_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [7:0]      dout_q, dout_d;
  logic [7:0]      rdata_q, rdata_d;
  logic            doe_q, doe_d;
  logic            we_n_q, we_n_d;
  logic            oe_n_q, oe_n_d;
  logic [2:0]      stb_q, stb_d;
  logic            sel_rnw;
  logic [AW-1:0]   sel_addr;
  logic [7:0]      sel_wdata;

  // Winner selection over the requests sampled in IDLE.
  always_comb begin
    win = C_NONE;
    if (ZXB_PRIO) begin
      if (zxb_req) win = C_ZXB;
      else if (rr_ptr == C_HST) begin
        if (hst_req)      win = C_HST;
        else if (dma_req) win = C_DMA;
      end else begin
        if (dma_req)      win = C_DMA;
        else if (hst_req) win = C_HST;
      end
    end else begin
      case (rr_ptr)
        C_ZXB: begin
          if (zxb_req)      win = C_ZXB;
          else if (dma_req) win = C_DMA;
          else if (hst_req) win = C_HST;
        end
        C_DMA: begin
          if (dma_req)      win = C_DMA;
          else if (hst_req) win = C_HST;
          else if (zxb_req) win = C_ZXB;
        end
        C_HST: begin
          if (hst_req)      win = C_HST;
          else if (zxb_req) win = C_ZXB;
          else if (dma_req) win = C_DMA;
        end
        default: win = C_NONE;
      endcase
    end
  end

  always_comb begin
    case (win)
      C_ZXB:   rr_adv = C_DMA;
      C_DMA:   rr_adv = C_HST;
      C_HST:   rr_adv = ZXB_PRIO ? C_DMA : C_ZXB;
      default: rr_adv = rr_ptr;
    endcase
  end

  always_comb begin
    sel_rnw   = 1'b1;
    sel_addr  = '0;
    sel_wdata = '0;
    case (win)
      C_ZXB: begin sel_rnw = zxb_rnw; sel_addr = zxb_addr; sel_wdata = zxb_wdata; end
      C_DMA: begin sel_rnw = dma_rnw; sel_addr = dma_addr; sel_wdata = dma_wdata; end
      C_HST: begin sel_rnw = hst_rnw; sel_addr = hst_addr; sel_wdata = hst_wdata; end
      default: ;
    endcase
  end

  always_comb begin
    state_d = state;
    owner_d = owner;
    rr_d    = rr_ptr;
    cnt_d   = cnt;
    rnw_d   = rnw;
    addr_d  = addr_q;
    dout_d  = dout_q;
    rdata_d = rdata_q;
    doe_d   = doe_q;
    we_n_d  = we_n_q;
    oe_n_d  = oe_n_q;
    stb_d   = '0;
    case (state)
      IDLE: begin
        if (win != C_NONE) begin
          owner_d = win;
          rnw_d   = sel_rnw;
          addr_d  = sel_addr;
          dout_d  = sel_wdata;
          if (sel_rnw) oe_n_d = 1'b0;
          else begin
            we_n_d = 1'b0;
            doe_d  = 1'b1;
          end
          cnt_d   = 4'(ACC_CYCLES - 1);
          state_d = ACCESS;
          if (!(ZXB_PRIO && win == C_ZXB)) rr_d = rr_adv;
        end
      end
      ACCESS: begin
        if (cnt == '0) begin
          if (rnw) rdata_d = sram_din;
          oe_n_d = 1'b1;
          we_n_d = 1'b1;
          case (owner)
            C_ZXB:   stb_d[0] = 1'b1;
            C_DMA:   stb_d[1] = 1'b1;
            C_HST:   stb_d[2] = 1'b1;
            default: ;
          endcase
          state_d = RECOV;
        end else begin
          cnt_d = cnt - 4'd1;
        end
      end
      RECOV: begin
        // Data stays driven through this cycle for SRAM hold time.
        doe_d   = 1'b0;
        owner_d = C_NONE;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      owner   <= C_NONE;
      rr_ptr  <= C_DMA;
      cnt     <= '0;
      rnw     <= 1'b1;
      addr_q  <= '0;
      dout_q  <= '0;
      rdata_q <= '0;
      doe_q   <= 1'b0;
      we_n_q  <= 1'b1;
      oe_n_q  <= 1'b1;
      stb_q   <= '0;
    end else begin
      state   <= state_d;
      owner   <= owner_d;
      rr_ptr  <= rr_d;
      cnt     <= cnt_d;
      rnw     <= rnw_d;
      addr_q  <= addr_d;
      dout_q  <= dout_d;
      rdata_q <= rdata_d;
      doe_q   <= doe_d;
      we_n_q  <= we_n_d;
      oe_n_q  <= oe_n_d;
      stb_q   <= stb_d;
    end
  end

  assign zxb_stb   = stb_q[0];
  assign dma_stb   = stb_q[1];
  assign hst_stb   = stb_q[2];
  assign rdata     = rdata_q;
  assign sram_addr = addr_q;
  assign sram_dout = dout_q;
  assign sram_doe  = doe_q;
  assign sram_we_n = we_n_q;
  assign sram_oe_n = oe_n_q;
  assign grant     = owner;
  assign busy      = (state != IDLE);

endmodule
